// File: rtl/fir_pkg.sv
// Shared widths for the polyphase FIR tap datapath (delay line + tap multiplier).
// Every fir_* module imports this package so both channel instances agree on sizes.
package fir_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int MUL_A_W = 28;
    localparam int TAP_W   = 32;
    localparam int PROD_W  = MUL_A_W + TAP_W;
    localparam int DEPTH   = 1 << ADDR_W;

    // Multiplier operand is the sample's MSBs; the low DATA_W-MUL_A_W bits are dropped.
    function automatic logic signed [MUL_A_W-1:0] mul_operand(input logic [DATA_W-1:0] s);
        return s[DATA_W-1 -: MUL_A_W];
    endfunction

endpackage

// File: rtl/fir_dpram.sv
// Sample delay line: one write port, one registered read port, read-first on collision.
// Every word is cleared by reset so a fresh delay line reads back as silence.
module fir_dpram
    import fir_pkg::*;
(
    input  logic              mclk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] di,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;

    // Sampled before this edge's write lands, so a same-address read returns old data.
    always_comb begin
        dout_d = mem_q[raddr];
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            if (we) begin
                mem_q[waddr] <= di;
            end
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/fir_smul.sv
// Registered full-precision signed multiplier, truncated sample MSBs times tap.
// One product per cycle; no rounding or saturation since the product width is exact.
module fir_smul
    import fir_pkg::*;
(
    input  logic               mclk,
    input  logic               reset,
    input  logic [MUL_A_W-1:0] a,
    input  logic [TAP_W-1:0]   b,
    output logic [PROD_W-1:0]  y
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] y_d;
    logic        [PROD_W-1:0] y_q;

    always_comb begin
        a_ext = $signed({{(PROD_W-MUL_A_W){a[MUL_A_W-1]}}, a});
        b_ext = $signed({{(PROD_W-TAP_W){b[TAP_W-1]}}, b});
        y_d   = a_ext * b_ext;
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/fir_tap_mult.sv
// One FIR channel: delay-line RAM feeding the tap multiplier.
// raddr -> dout is 1 cycle, dout/tap -> y is 1 cycle; the caller tracks the latency.
module fir_tap_mult
    import fir_pkg::*;
(
    input  logic              mclk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] di,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [TAP_W-1:0]  tap,
    output logic [DATA_W-1:0] dout,
    output logic [PROD_W-1:0] y
);

    logic [DATA_W-1:0]  rd_data;
    logic [MUL_A_W-1:0] mul_a;

    fir_dpram u_dpram (
        .mclk  (mclk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .di    (di),
        .raddr (raddr),
        .dout  (rd_data)
    );

    assign mul_a = mul_operand(rd_data);

    fir_smul u_smul (
        .mclk  (mclk),
        .reset (reset),
        .a     (mul_a),
        .b     (tap),
        .y     (y)
    );

    assign dout = rd_data;

endmodule

// File: tb/tb_fir_tap_mult.sv
// Directed bench for fir_tap_mult: reset, write/read, truncation, extremes,
// read-during-write, address wrap with back-to-back reads, and mid-burst reset.
module tb_fir_tap_mult;

    logic        mclk;
    logic        reset;
    logic        we;
    logic [6:0]  waddr;
    logic [31:0] di;
    logic [6:0]  raddr;
    logic [31:0] tap;
    logic [31:0] dout;
    logic [59:0] y;

    int n_checks = 0;
    int n_fail   = 0;

    fir_tap_mult dut (
        .mclk  (mclk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .di    (di),
        .raddr (raddr),
        .tap   (tap),
        .dout  (dout),
        .y     (y)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic write_word(input logic [6:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; di = d;
        step();
        we = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] a, input logic [31:0] t,
                           output logic [31:0] d_s, output logic [59:0] y_s);
        raddr = a;
        step();
        d_s = dout;
        tap = t;
        step();
        y_s = y;
    endtask

    task automatic test_reset();
        logic [6:0] addrs [3];
        addrs[0] = 7'd0; addrs[1] = 7'd5; addrs[2] = 7'd127;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dout !== 32'd0 || y !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_state dout=%h y=%h required 0/0", dout, y);
        end
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            raddr = addrs[i];
            tap   = 32'hDEAD_BEEF + i;
            step();
            n_checks++;
            if (dout !== 32'd0 || y !== 60'd0) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d dout=%h y=%h required 0/0", addrs[i], dout, y);
            end
        end
        tap = 32'h7FFF_FFFF;
        step();
        n_checks++;
        if (y !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_read_tail y=%h required 0", y);
        end
    endtask

    task automatic test_write_read();
        write_word(7'd3, 32'h7FFF_FFF0);
        write_word(7'd4, 32'h8000_0000);
        raddr = 7'd3;
        step();
        n_checks++;
        if (dout !== 32'h7FFF_FFF0) begin
            n_fail++;
            $display("FAIL wr_dout3 dout=%h required 7ffffff0", dout);
        end
        raddr = 7'd4;
        tap   = 32'd2;
        step();
        n_checks++;
        if (dout !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL wr_dout4 dout=%h required 80000000", dout);
        end
        n_checks++;
        if (y !== 60'h0000_0000_FFF_FFFE) begin
            n_fail++;
            $display("FAIL wr_y3 y=%h required 00000000ffffffe", y);
        end
        tap = 32'd2;
        step();
        n_checks++;
        if (y !== 60'hFFF_FFFF_F000_0000) begin
            n_fail++;
            $display("FAIL wr_y4 y=%h required ffffffff0000000", y);
        end
    endtask

    task automatic test_truncation();
        logic [31:0] d_s;
        logic [59:0] y_s;
        write_word(7'd10, 32'h0000_000F);
        do_read(7'd10, 32'd1000, d_s, y_s);
        n_checks++;
        if (y_s !== 60'd0) begin
            n_fail++;
            $display("FAIL trunc_low4 y=%h required 0", y_s);
        end
        write_word(7'd11, 32'h0000_0010);
        do_read(7'd11, 32'hFFFF_FFFF, d_s, y_s);
        n_checks++;
        if (y_s !== {60{1'b1}}) begin
            n_fail++;
            $display("FAIL trunc_minus1 y=%h required fffffffffffffff", y_s);
        end
    endtask

    task automatic test_extremes();
        logic [31:0] d_s;
        logic [59:0] y_s;
        logic [59:0] exp_y;
        write_word(7'd20, 32'h8000_0000);
        do_read(7'd20, 32'h8000_0000, d_s, y_s);
        exp_y = 60'(longint'(1) << 58);
        n_checks++;
        if (y_s !== exp_y) begin
            n_fail++;
            $display("FAIL ext_negneg y=%h required %h", y_s, exp_y);
        end
        do_read(7'd20, 32'h7FFF_FFFF, d_s, y_s);
        exp_y = 60'(-((longint'(1) << 58) - (longint'(1) << 27)));
        n_checks++;
        if (y_s !== exp_y) begin
            n_fail++;
            $display("FAIL ext_negpos y=%h required %h", y_s, exp_y);
        end
    endtask

    task automatic test_read_during_write();
        write_word(7'd9, 32'h0000_0100);
        we = 1'b1; waddr = 7'd9; di = 32'h0000_0200; raddr = 7'd9;
        step();
        we = 1'b0;
        n_checks++;
        if (dout !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL rdw_old dout=%h required 00000100", dout);
        end
        step();
        n_checks++;
        if (dout !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL rdw_new dout=%h required 00000200", dout);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  addrs [4];
        logic [31:0] vals  [4];
        logic [59:0] exp_y;
        addrs[0] = 7'd126; vals[0] = 32'h0000_0100;
        addrs[1] = 7'd127; vals[1] = 32'h1234_5670;
        addrs[2] = 7'd0;   vals[2] = 32'hFEDC_BA90;
        addrs[3] = 7'd1;   vals[3] = 32'hFFFF_FFF0;
        for (int i = 0; i < 4; i++) write_word(addrs[i], vals[i]);
        tap = 32'd1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) raddr = addrs[k];
            step();
            if (k < 4) begin
                n_checks++;
                if (dout !== vals[k]) begin
                    n_fail++;
                    $display("FAIL b2b_dout%0d dout=%h required %h", k, dout, vals[k]);
                end
            end
            if (k >= 1) begin
                exp_y = 60'(longint'(signed'(vals[k-1])) >>> 4);
                n_checks++;
                if (y !== exp_y) begin
                    n_fail++;
                    $display("FAIL b2b_y%0d y=%h required %h", k - 1, y, exp_y);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [6:0] addrs [4];
        addrs[0] = 7'd126; addrs[1] = 7'd127; addrs[2] = 7'd0; addrs[3] = 7'd1;
        tap = 32'd1;
        raddr = addrs[0];
        step();
        raddr = addrs[1];
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (dout !== 32'd0 || y !== 60'd0) begin
            n_fail++;
            $display("FAIL midrst_async dout=%h y=%h required 0/0", dout, y);
        end
        step();
        reset = 1'b0;
        tap = 32'h7FFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) raddr = addrs[k];
            step();
            n_checks++;
            if (dout !== 32'd0 || y !== 60'd0) begin
                n_fail++;
                $display("FAIL midrst_read%0d dout=%h y=%h required 0/0", k, dout, y);
            end
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; di = '0; raddr = '0; tap = '0;
        test_reset();
        test_write_read();
        test_truncation();
        test_extremes();
        test_read_during_write();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
